// File: rtl/prog_loader.sv
// prog_loader: host boot/program loader for the pipelined CPU.
// Decodes a byte stream (valid/ready) into command frames. Load frames are
// packed into 32-bit words and written through the CPU's external imem/dmem
// write ports. START/HALT commands drive the CPU enable input.
//
// Ports:
//   clk, arst_n            clock, asynchronous active-low reset
//   in_data/in_valid       stream byte and its valid strobe
//   in_ready               byte is accepted this cycle (low only while writing)
//   imem_addr/wen/wdata    instruction-memory write port (byte address)
//   dmem_addr/wen/wdata    data-memory write port (byte address)
//   cpu_enable             CPU run enable
//   busy                   a frame is in progress
//   error                  sticky illegal-command flag
module prog_loader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [31:0]       imem_addr,
  output logic              imem_wen,
  output logic [DATA_W-1:0] imem_wdata,
  output logic [31:0]       dmem_addr,
  output logic              dmem_wen,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              cpu_enable,
  output logic              busy,
  output logic              error
);

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned IDX_W    = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W / BYTE_W - 1);

  localparam logic [7:0] CMD_LOAD_IMEM = 8'h01;
  localparam logic [7:0] CMD_LOAD_DMEM = 8'h02;
  localparam logic [7:0] CMD_START     = 8'h03;
  localparam logic [7:0] CMD_HALT      = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_ADR_HI,
    S_ADR_LO,
    S_DATA,
    S_WRITE
  } state_e;

  state_e              state_q, state_d;
  logic                tgt_dmem_q, tgt_dmem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    waddr_q, waddr_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [IDX_W-1:0]    bidx_q, bidx_d;
  logic                cpu_en_q, cpu_en_d;
  logic                err_q, err_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic                imem_wen_q, imem_wen_d;
  logic [DATA_W-1:0]   imem_wdata_q, imem_wdata_d;
  logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
  logic                dmem_wen_q, dmem_wen_d;
  logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;

  logic                accept_c;
  logic [DATA_W-1:0]   word_next_c;
  logic [ADDR_W-1:0]   byte_addr_c;

  // A byte moves only when both sides agree; in_ready_q already tracks state.
  assign accept_c    = in_valid && in_ready_q;
  assign word_next_c = {word_q[DATA_W-BYTE_W-1:0], in_data};
  assign byte_addr_c = ADDR_W'({waddr_q, 2'b00});

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d      = state_q;
    tgt_dmem_d   = tgt_dmem_q;
    cnt_d        = cnt_q;
    waddr_d      = waddr_q;
    word_d       = word_q;
    bidx_d       = bidx_q;
    cpu_en_d     = cpu_en_q;
    err_d        = err_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    imem_wen_d   = 1'b0;
    dmem_wen_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          unique case (in_data)
            CMD_LOAD_IMEM, CMD_LOAD_DMEM: begin
              tgt_dmem_d = (in_data == CMD_LOAD_DMEM);
              cpu_en_d   = 1'b0;
              state_d    = S_CNT_HI;
            end
            CMD_START: cpu_en_d = 1'b1;
            CMD_HALT:  cpu_en_d = 1'b0;
            default:   err_d    = 1'b1;
          endcase
        end
      end

      // Count and address arrive MSB first; shifting twice fills the field.
      S_CNT_HI: begin
        if (accept_c) begin
          cnt_d   = CNT_W'({cnt_q, in_data});
          state_d = S_CNT_LO;
        end
      end

      S_CNT_LO: begin
        if (accept_c) begin
          cnt_d   = CNT_W'({cnt_q, in_data});
          state_d = S_ADR_HI;
        end
      end

      S_ADR_HI: begin
        if (accept_c) begin
          waddr_d = CNT_W'({waddr_q, in_data});
          state_d = S_ADR_LO;
        end
      end

      // A zero-length frame ends here without touching memory.
      S_ADR_LO: begin
        if (accept_c) begin
          waddr_d = CNT_W'({waddr_q, in_data});
          bidx_d  = '0;
          state_d = (cnt_q == '0) ? S_IDLE : S_DATA;
        end
      end

      // Final byte of a word loads the selected port's registers so the
      // write strobe appears in the very next cycle.
      S_DATA: begin
        if (accept_c) begin
          word_d = word_next_c;
          bidx_d = bidx_q + IDX_W'(1);
          if (bidx_q == LAST_IDX) begin
            state_d = S_WRITE;
            if (tgt_dmem_q) begin
              dmem_wen_d   = 1'b1;
              dmem_addr_d  = byte_addr_c;
              dmem_wdata_d = word_next_c;
            end else begin
              imem_wen_d   = 1'b1;
              imem_addr_d  = byte_addr_c;
              imem_wdata_d = word_next_c;
            end
          end
        end
      end

      // Single write cycle; word address wraps naturally at the field width.
      S_WRITE: begin
        waddr_d = waddr_q + CNT_W'(1);
        cnt_d   = cnt_q - CNT_W'(1);
        bidx_d  = '0;
        state_d = (cnt_q == CNT_W'(1)) ? S_IDLE : S_DATA;
      end

      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d != S_WRITE);
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= S_IDLE;
      tgt_dmem_q   <= 1'b0;
      cnt_q        <= '0;
      waddr_q      <= '0;
      word_q       <= '0;
      bidx_q       <= '0;
      cpu_en_q     <= 1'b0;
      err_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      imem_addr_q  <= '0;
      imem_wen_q   <= 1'b0;
      imem_wdata_q <= '0;
      dmem_addr_q  <= '0;
      dmem_wen_q   <= 1'b0;
      dmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      tgt_dmem_q   <= tgt_dmem_d;
      cnt_q        <= cnt_d;
      waddr_q      <= waddr_d;
      word_q       <= word_d;
      bidx_q       <= bidx_d;
      cpu_en_q     <= cpu_en_d;
      err_q        <= err_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      imem_addr_q  <= imem_addr_d;
      imem_wen_q   <= imem_wen_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wen_q   <= dmem_wen_d;
      dmem_wdata_q <= dmem_wdata_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wen   = imem_wen_q;
  assign imem_wdata = imem_wdata_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wen   = dmem_wen_q;
  assign dmem_wdata = dmem_wdata_q;
  assign cpu_enable = cpu_en_q;
  assign busy       = busy_q;
  assign error      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: drives byte streams with random valid gaps and
// compares memory writes and status flags against a frame-level parser model.
module tb_prog_loader;

  logic        clk;
  logic        arst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] imem_addr;
  logic        imem_wen;
  logic [31:0] imem_wdata;
  logic [31:0] dmem_addr;
  logic        dmem_wen;
  logic [31:0] dmem_wdata;
  logic        cpu_enable;
  logic        busy;
  logic        error;

  prog_loader #(.DATA_W(32), .CNT_W(16)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_addr  (imem_addr),
    .imem_wen   (imem_wen),
    .imem_wdata (imem_wdata),
    .dmem_addr  (dmem_addr),
    .dmem_wen   (dmem_wen),
    .dmem_wdata (dmem_wdata),
    .cpu_enable (cpu_enable),
    .busy       (busy),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          dm;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          tests_run;
  int          tests_failed;
  wr_t         exp_q[$];
  wr_t         obs_q[$];
  logic [7:0]  tx_b[$];
  bit          tx_last[$];
  logic [31:0] wsrc[$];
  bit          m_cpu;
  bit          m_err;
  bit          cur_last;

  // Reference model: parse the whole stream frame by frame.
  task automatic model_run();
    int          i;
    int          n;
    logic [7:0]  c;
    logic [15:0] a;
    logic [31:0] w;
    wr_t         e;
    i = 0;
    while (i < tx_b.size()) begin
      c = tx_b[i];
      i = i + 1;
      if (c == 8'h01 || c == 8'h02) begin
        n = int'({tx_b[i], tx_b[i+1]});
        a = {tx_b[i+2], tx_b[i+3]};
        i = i + 4;
        m_cpu = 1'b0;
        for (int k = 0; k < n; k++) begin
          w = {tx_b[i], tx_b[i+1], tx_b[i+2], tx_b[i+3]};
          i = i + 4;
          e.dm = (c == 8'h02);
          e.addr = 32'(a) * 32'd4;
          e.data = w;
          exp_q.push_back(e);
          a = a + 16'd1;
        end
      end else if (c == 8'h03) begin
        m_cpu = 1'b1;
      end else if (c == 8'h04) begin
        m_cpu = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic push_b(input logic [7:0] b, input bit last);
    tx_b.push_back(b);
    tx_last.push_back(last);
  endtask

  // Load frame using the first n entries of wsrc as the word payload.
  task automatic add_load(input bit dm, input int n, input logic [15:0] a);
    logic [15:0] nn;
    logic [31:0] w;
    nn = 16'(n);
    push_b(dm ? 8'h02 : 8'h01, 1'b0);
    push_b(nn[15:8], 1'b0);
    push_b(nn[7:0], 1'b0);
    push_b(a[15:8], 1'b0);
    push_b(a[7:0], 1'b0);
    for (int k = 0; k < n; k++) begin
      w = wsrc[k];
      push_b(w[31:24], 1'b0);
      push_b(w[23:16], 1'b0);
      push_b(w[15:8], 1'b0);
      push_b(w[7:0], 1'b1);
    end
  endtask

  task automatic clear_tx();
    tx_b.delete();
    tx_last.delete();
    exp_q.delete();
    obs_q.delete();
  endtask

  // Present one byte after 0..gap_max idle cycles; returns after acceptance.
  task automatic send(input logic [7:0] b, input bit last, input int gap_max);
    int g;
    bit ok;
    @(posedge clk); #2;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    in_valid = 1'b0;
    repeat (g) begin @(posedge clk); #2; end
    in_data  = b;
    cur_last = last;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    cur_last = 1'b0;
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL handshake_timeout: byte %h not accepted within 50 cycles", b);
    end
  endtask

  // Send the queued stream, wait for idle, then compare writes and flags.
  task automatic run_stream(input string name, input int gap_max);
    bit idle;
    model_run();
    obs_q.delete();
    for (int i = 0; i < tx_b.size(); i++) send(tx_b[i], tx_last[i], gap_max);
    idle = 1'b0;
    for (int t = 0; t < 100 && !idle; t++) begin
      @(negedge clk);
      idle = (busy === 1'b0);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (!idle) begin
      tests_failed++;
      $display("FAIL %s idle_timeout: busy=%b, expected 0", name, busy);
    end
    tests_run++;
    if (obs_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL %s write_count: got %0d, expected %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i].dm !== exp_q[i].dm || obs_q[i].addr !== exp_q[i].addr ||
          obs_q[i].data !== exp_q[i].data) begin
        tests_failed++;
        $display("FAIL %s write%0d: got dm=%0d addr=%h data=%h, expected dm=%0d addr=%h data=%h",
                 name, i, obs_q[i].dm, obs_q[i].addr, obs_q[i].data,
                 exp_q[i].dm, exp_q[i].addr, exp_q[i].data);
      end
    end
    tests_run++;
    if (cpu_enable !== m_cpu) begin
      tests_failed++;
      $display("FAIL %s cpu_enable: got %b, expected %b", name, cpu_enable, m_cpu);
    end
    tests_run++;
    if (error !== m_err) begin
      tests_failed++;
      $display("FAIL %s error: got %b, expected %b", name, error, m_err);
    end
    clear_tx();
  endtask

  // Cycle monitor: write latency, in_ready vs write cycle, exclusivity,
  // CPU held off during frames, and capture of write transactions.
  initial begin : monitor
    bit  pend;
    bit  wen;
    wr_t o;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        pend = 1'b0;
      end else begin
        wen = (imem_wen === 1'b1) || (dmem_wen === 1'b1);
        tests_run++;
        if (wen !== pend) begin
          tests_failed++;
          $display("FAIL wen_timing @%0t: got wen=%b, expected %b", $time, wen, pend);
        end
        tests_run++;
        if (in_ready !== !wen) begin
          tests_failed++;
          $display("FAIL in_ready @%0t: got %b, expected %b", $time, in_ready, !wen);
        end
        if (imem_wen === 1'b1 && dmem_wen === 1'b1) begin
          tests_run++;
          tests_failed++;
          $display("FAIL wen_exclusive @%0t: got both strobes 1, expected at most one", $time);
        end
        if (busy === 1'b1 && cpu_enable !== 1'b0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL cpu_during_frame @%0t: got %b, expected 0", $time, cpu_enable);
        end
        if (imem_wen === 1'b1) begin
          o.dm = 1'b0; o.addr = imem_addr; o.data = imem_wdata;
          obs_q.push_back(o);
        end
        if (dmem_wen === 1'b1) begin
          o.dm = 1'b1; o.addr = dmem_addr; o.data = dmem_wdata;
          obs_q.push_back(o);
        end
        pend = (in_valid === 1'b1) && (in_ready === 1'b1) && cur_last;
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    tests_run++;
    if (in_ready !== 1'b1 || imem_wen !== 1'b0 || dmem_wen !== 1'b0 ||
        imem_addr !== 32'd0 || imem_wdata !== 32'd0 || dmem_addr !== 32'd0 ||
        dmem_wdata !== 32'd0 || cpu_enable !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: got rdy=%b iw=%b dw=%b ia=%h id=%h da=%h dd=%h cpu=%b busy=%b err=%b, expected rdy=1 rest 0",
               name, in_ready, imem_wen, dmem_wen, imem_addr, imem_wdata,
               dmem_addr, dmem_wdata, cpu_enable, busy, error);
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    #1;
    check_reset_outputs("reset_values");
    repeat (3) @(posedge clk);
    #3 arst_n = 1'b1;
    m_cpu = 1'b0;
    m_err = 1'b0;
    clear_tx();
  endtask

  task automatic test_imem_load();
    wsrc = '{32'hDEADBEEF, 32'h00000001};
    add_load(1'b0, 2, 16'h0010);
    run_stream("imem_load", 0);
  endtask

  task automatic test_dmem_wrap();
    wsrc = '{32'h12345678};
    add_load(1'b1, 1, 16'hFFFF);
    run_stream("dmem_top", 1);
    wsrc = '{32'hCAFEF00D, 32'h0BADBEEF};
    add_load(1'b1, 2, 16'hFFFF);
    run_stream("dmem_wrap", 1);
  endtask

  task automatic test_start_halt();
    push_b(8'h03, 1'b0);
    run_stream("start", 0);
    wsrc.delete();
    add_load(1'b0, 0, 16'h0000);
    run_stream("zero_len_load", 0);
    push_b(8'h03, 1'b0);
    push_b(8'h04, 1'b0);
    run_stream("start_halt", 2);
  endtask

  task automatic test_error();
    push_b(8'h7F, 1'b0);
    run_stream("illegal_cmd", 0);
    push_b(8'h03, 1'b0);
    run_stream("start_after_error", 0);
  endtask

  task automatic test_random_gaps();
    wsrc.delete();
    for (int k = 0; k < 3; k++) wsrc.push_back($urandom);
    add_load(1'b0, 3, 16'($urandom));
    run_stream("gapped_load", 3);
  endtask

  task automatic test_random_frames();
    int sel;
    int n;
    for (int f = 0; f < 12; f++) begin
      sel = int'($urandom_range(9, 0));
      if (sel < 3) begin
        wsrc.delete();
        n = int'($urandom_range(3, 0));
        for (int k = 0; k < n; k++) wsrc.push_back($urandom);
        add_load(1'b0, n, (sel == 0) ? 16'hFFFE : 16'($urandom));
      end else if (sel < 6) begin
        wsrc.delete();
        n = int'($urandom_range(3, 0));
        for (int k = 0; k < n; k++) wsrc.push_back({8'h03, 8'h04, 16'($urandom)});
        add_load(1'b1, n, 16'($urandom));
      end else if (sel < 8) begin
        push_b(8'h03, 1'b0);
      end else if (sel == 8) begin
        push_b(8'h04, 1'b0);
      end else begin
        push_b(8'h80 | 8'($urandom_range(127, 0)), 1'b0);
      end
    end
    run_stream("random_frames", 2);
  endtask

  task automatic test_reset_midframe();
    wsrc = '{32'hA5A5A5A5, 32'h5A5A5A5A};
    add_load(1'b1, 2, 16'h0100);
    obs_q.delete();
    for (int i = 0; i < 7; i++) send(tx_b[i], tx_last[i], 1);
    @(posedge clk);
    #3 arst_n = 1'b0;
    #1;
    check_reset_outputs("reset_midframe");
    repeat (3) @(negedge clk);
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL reset_midframe_writes: got %0d writes, expected 0", obs_q.size());
    end
    @(posedge clk);
    #3 arst_n = 1'b1;
    m_cpu = 1'b0;
    m_err = 1'b0;
    clear_tx();
    wsrc = '{32'h01020304, 32'hF0E0D0C0};
    add_load(1'b1, 2, 16'h0100);
    run_stream("after_reset_load", 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    in_data      = 8'h00;
    in_valid     = 1'b0;
    cur_last     = 1'b0;
    arst_n       = 1'b1;
    m_cpu        = 1'b0;
    m_err        = 1'b0;
    #2;
    test_reset();
    test_imem_load();
    test_dmem_wrap();
    test_start_halt();
    test_error();
    test_reset();
    test_random_gaps();
    test_random_frames();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
